insn_fetch: RTL and testbench

//  Instruction fetch unit: producer side of the decoder's instruction input.

---
 rtl/insn_fetch.sv | 192 +++++++++++++++++++
 tb/tb_insn_fetch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch.sv
// Instruction fetch unit: owns the PC, issues one word read at a time on a req/ack
// port and hands each fetched word to the decoder over a valid/ready handshake.
module insn_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // memory read port
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  input  logic              i_mem_err,
  // decoder side
  output logic [31:0]       o_insn,
  output logic [ADDR_W-1:0] o_insn_pc,
  output logic              o_insn_valid,
  input  logic              i_insn_ready,
  // control
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_halt,
  output logic              o_halted,
  output logic              o_fault,
  // debug view of the FSM
  output logic [2:0]        o_dbg_state
);

  // Handshakes: a word moves to the decoder on an edge where o_insn_valid and
  // i_insn_ready are both 1; o_insn/o_insn_pc never change while valid is held.
  // A read completes on an edge where o_mem_req and i_mem_ack are both 1;
  // o_mem_req/o_mem_addr never change until that edge.
  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_HOLD  = 3'd1,
    S_DRAIN = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};
  localparam logic [ADDR_W-1:0] PC_STEP          = ADDR_W'(4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic [31:0]       insn_q, insn_d;
  logic [ADDR_W-1:0] insn_pc_q, insn_pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic              halt_pend_q, halt_pend_d;

  logic              take_halt;
  logic              take_redirect;
  logic              req_pending;
  logic [ADDR_W-1:0] redirect_pc_aligned;
  logic              unused_redirect_lsb;

  assign redirect_pc_aligned = {i_redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^i_redirect_pc[1:0];

  // Halt is only honoured while actively fetching; it beats a same-cycle redirect.
  assign take_halt     = i_halt && ((state_q == S_FETCH) || (state_q == S_HOLD));
  assign take_redirect = i_redirect && !take_halt;
  assign req_pending   = req_q && !i_mem_ack;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    req_d       = req_q;
    insn_d      = insn_q;
    insn_pc_d   = insn_pc_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    halt_pend_d = halt_pend_q;

    if (take_halt) begin
      valid_d  = 1'b0;
      halted_d = 1'b0;
      if (req_pending) begin
        state_d     = S_DRAIN;
        halt_pend_d = 1'b1;
      end else begin
        req_d    = 1'b0;
        halted_d = 1'b1;
        state_d  = S_HALT;
      end
    end else if (take_redirect) begin
      pc_d        = redirect_pc_aligned;
      valid_d     = 1'b0;
      fault_d     = 1'b0;
      halt_pend_d = 1'b0;
      halted_d    = 1'b0;
      if (req_pending) begin
        state_d = S_DRAIN;
      end else begin
        req_d   = 1'b0;
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!req_q) begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end else if (i_mem_ack) begin
            req_d = 1'b0;
            if (i_mem_err) begin
              fault_d = 1'b1;
              state_d = S_FAULT;
            end else begin
              insn_d    = i_mem_rdata;
              insn_pc_d = addr_q;
              valid_d   = 1'b1;
              state_d   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (i_insn_ready) begin
            valid_d = 1'b0;
            pc_d    = pc_q + PC_STEP;
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          // The stale read's data and error status are thrown away.
          if (i_mem_ack) begin
            req_d = 1'b0;
            if (halt_pend_q) begin
              halt_pend_d = 1'b0;
              halted_d    = 1'b1;
              state_d     = S_HALT;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
        S_HALT, S_FAULT: begin
          req_d   = 1'b0;
          valid_d = 1'b0;
        end
        default: begin
          req_d   = 1'b0;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC_ALIGNED;
      addr_q      <= RESET_PC_ALIGNED;
      req_q       <= 1'b0;
      insn_q      <= '0;
      insn_pc_q   <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      insn_q      <= insn_d;
      insn_pc_q   <= insn_pc_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign o_mem_req    = req_q;
  assign o_mem_addr   = addr_q;
  assign o_insn       = insn_q;
  assign o_insn_pc    = insn_pc_q;
  assign o_insn_valid = valid_q;
  assign o_halted     = halted_q;
  assign o_fault      = fault_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: a latency-programmable memory responder and a scoreboard of
// expected {pc, insn} pairs checked as the decoder side accepts each word.
module tb_insn_fetch;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        mem_req, mem_ack, mem_err;
  logic [31:0] mem_addr, mem_rdata;
  logic [31:0] insn, insn_pc;
  logic        insn_valid, ready;
  logic        redirect, halt;
  logic [31:0] redirect_pc;
  logic        halted, fault;
  logic [2:0]  dbg_state;

  logic        b_rst_n;
  logic        b_req, b_ack;
  logic [31:0] b_addr, b_rdata;
  logic [31:0] b_insn, b_insn_pc;
  logic        b_valid, b_ready, b_halted, b_fault;
  logic [2:0]  b_dbg_state;

  int          n_vec;
  int          n_err;
  int          n_acc;
  int          mem_lat;
  logic        err_en;
  logic [31:0] err_addr;
  logic [63:0] exp_q[$];

  insn_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack),
    .i_mem_rdata(mem_rdata), .i_mem_err(mem_err),
    .o_insn(insn), .o_insn_pc(insn_pc), .o_insn_valid(insn_valid), .i_insn_ready(ready),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .i_halt(halt),
    .o_halted(halted), .o_fault(fault), .o_dbg_state(dbg_state)
  );

  insn_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n),
    .o_mem_req(b_req), .o_mem_addr(b_addr), .i_mem_ack(b_ack),
    .i_mem_rdata(b_rdata), .i_mem_err(1'b0),
    .o_insn(b_insn), .o_insn_pc(b_insn_pc), .o_insn_valid(b_valid), .i_insn_ready(b_ready),
    .i_redirect(1'b0), .i_redirect_pc(32'h0), .i_halt(1'b0),
    .o_halted(b_halted), .o_fault(b_fault), .o_dbg_state(b_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, pc ^ PAT});
  endtask

  // memory responder: acks a request after mem_lat extra cycles
  initial begin : mem_model
    int waited;
    waited    = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    mem_err   = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_err = 1'b0;
      if (rst_n && mem_req) begin
        if (waited >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr ^ PAT;
          mem_err   = err_en && (mem_addr == err_addr);
          waited    = 0;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  // scoreboard: pop on every cycle that will transfer a word to the decoder
  initial begin : sb_monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && insn_valid && ready && !halt && !redirect) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_insn", {insn_pc, insn}, e);
        end
        n_acc++;
      end
    end
  end

  initial begin : main
    int base;
    n_vec = 0; n_err = 0; n_acc = 0;
    mem_lat = 1; err_en = 1'b0; err_addr = 32'h0;
    rst_n = 1'b0; b_rst_n = 1'b0;
    ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    b_ack = 1'b0; b_rdata = '0; b_ready = 1'b0;

    repeat (3) cyc();
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_valid", 64'(insn_valid), 64'd0);
    check("rst_insn", {insn_pc, insn}, 64'd0);
    check("rst_flags", {62'd0, halted, fault}, 64'd0);
    rst_n = 1'b1;

    // T1: in-order fetch of 0x0, 0x4, 0x8
    ready = 1'b1;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    base = n_acc;
    cyc();
    check("t1_first_req", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h0});
    for (int i = 0; i < 60 && (n_acc - base) < 3; i++) cyc();
    check("t1_count", 64'(n_acc - base), 64'd3);
    ready = 1'b0;

    // T2: stall in HOLD with word 0xC
    for (int i = 0; i < 20 && !insn_valid; i++) cyc();
    check("t2_valid", 64'(insn_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t2_hold", {insn_pc, insn}, {32'hC, 32'hC ^ PAT});
      check("t2_req", {62'd0, mem_req, insn_valid}, 64'd1);
    end
    push_exp(32'hC);
    ready = 1'b1;

    // T3: redirect to 0x103 while the read of 0x10 is outstanding
    cyc();
    ready = 1'b0;
    mem_lat = 3;
    cyc();
    check("t3_req", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h10});
    redirect = 1'b1; redirect_pc = 32'h103;
    cyc();
    redirect = 1'b0;
    check("t3_drain", {30'd0, mem_req, insn_valid, mem_addr}, {30'd0, 2'b10, 32'h10});
    cyc();
    check("t3_drain2", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h10});
    cyc();
    check("t3_drain3", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h10});
    cyc();
    check("t3_gap", {62'd0, mem_req, insn_valid}, 64'd0);
    cyc();
    check("t3_newreq", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h100});
    mem_lat = 1;
    push_exp(32'h100);
    ready = 1'b1;
    base = n_acc;
    for (int i = 0; i < 30 && (n_acc - base) < 1; i++) cyc();
    check("t3_count", 64'(n_acc - base), 64'd1);
    ready = 1'b0;

    // T4: halt and redirect together while holding 0x104
    for (int i = 0; i < 20 && !insn_valid; i++) cyc();
    check("t4_valid", {insn_pc, 31'd0, insn_valid}, {32'h104, 32'd1});
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; ready = 1'b1;
    cyc();
    halt = 1'b0; redirect = 1'b0; ready = 1'b0;
    check("t4_halted", {61'd0, halted, mem_req, insn_valid}, {61'd0, 3'b100});
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t4_stay", {62'd0, halted, mem_req}, {62'd0, 2'b10});
    end
    redirect = 1'b1; redirect_pc = 32'h40;
    cyc();
    redirect = 1'b0;
    check("t4_unhalt", 64'(halted), 64'd0);
    cyc();
    check("t4_req", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h40});

    // T5: bus error on 0x4C, then redirect to 0x0
    err_en = 1'b1; err_addr = 32'h4C;
    push_exp(32'h40); push_exp(32'h44); push_exp(32'h48);
    base = n_acc;
    ready = 1'b1;
    for (int i = 0; i < 60 && !fault; i++) cyc();
    check("t5_fault", {61'd0, fault, mem_req, insn_valid}, {61'd0, 3'b100});
    check("t5_count", 64'(n_acc - base), 64'd3);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t5_sticky", {61'd0, fault, mem_req, insn_valid}, {61'd0, 3'b100});
    end
    ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0;
    cyc();
    redirect = 1'b0;
    check("t5_clear", 64'(fault), 64'd0);
    cyc();
    check("t5_req", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h0});
    push_exp(32'h0);
    ready = 1'b1;
    base = n_acc;
    for (int i = 0; i < 30 && (n_acc - base) < 1; i++) cyc();
    check("t5_count2", 64'(n_acc - base), 64'd1);
    ready = 1'b0;
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    // T6: PC wrap from 0xFFFF_FFFC, then asynchronous reset mid-request
    b_rst_n = 1'b1;
    cyc();
    check("t6_req", {31'd0, b_req, b_addr}, {31'd0, 1'b1, 32'hFFFF_FFFC});
    b_ack = 1'b1; b_rdata = 32'hFFFF_FFFC ^ PAT;
    cyc();
    b_ack = 1'b0;
    check("t6_insn", {b_insn_pc, b_insn}, {32'hFFFF_FFFC, 32'h5A5A_FFFC});
    check("t6_valid", 64'(b_valid), 64'd1);
    b_ready = 1'b1;
    cyc();
    b_ready = 1'b0;
    check("t6_accept", {62'd0, b_valid, b_req}, 64'd0);
    cyc();
    check("t6_wrap", {31'd0, b_req, b_addr}, {31'd0, 1'b1, 32'h0});
    b_rst_n = 1'b0;
    #1;
    check("t6_async_req", {61'd0, b_req, b_valid, b_halted}, 64'd0);
    check("t6_async_insn", {b_insn_pc, b_insn}, 64'd0);
    check("t6_async_fault", 64'(b_fault), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
